// File: rtl/conv_pipe_mc.sv
// Multi-channel SIZE x SIZE convolution engine: 3-stage pipeline, valid/ready, loadable kernel.
// Define CONV_SAT_EN to clamp the result to OUT_W; otherwise it wraps to the OUT_W LSBs.
module conv_pipe_mc #(
   parameter int SIZE      = 3,
   parameter int WIDTH_BIT = 8,
   parameter int CH        = 2,
   parameter int OUT_SHIFT = 0,
   parameter int OUT_W     = 8
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  k_we,
   input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] k_ch,
   input  logic [$clog2(SIZE)-1:0]               k_row,
   input  logic [$clog2(SIZE)-1:0]               k_col,
   input  logic signed [WIDTH_BIT-1:0]           k_data,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [CH*SIZE*SIZE*WIDTH_BIT-1:0]     in_win,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic signed [OUT_W-1:0]               out_data,
   output logic                                  busy
);

   localparam int ACC_W = 2*WIDTH_BIT + $clog2(SIZE*SIZE*CH);
   localparam int PW    = 2*WIDTH_BIT;
   localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
   localparam int IX_W  = $clog2(SIZE);

   // Lookup masks marking which index codes address a real coefficient.
   localparam logic [(1<<CH_W)-1:0] CH_OK = {(1<<CH_W){1'b1}} >> ((1<<CH_W) - CH);
   localparam logic [(1<<IX_W)-1:0] IX_OK = {(1<<IX_W){1'b1}} >> ((1<<IX_W) - SIZE);
   localparam logic signed [ACC_W:0] RND_ADD = (ACC_W+1)'((2 ** OUT_SHIFT) / 2);

   logic signed [WIDTH_BIT-1:0] kern_q   [CH][SIZE][SIZE];
   logic signed [PW-1:0]        prod_q   [CH][SIZE][SIZE];
   logic signed [PW-1:0]        prod_d   [CH][SIZE][SIZE];
   logic signed [ACC_W-1:0]     rowSum_q [CH][SIZE];
   logic signed [ACC_W-1:0]     rowSum_d [CH][SIZE];
   logic signed [ACC_W-1:0]     total;
   logic signed [ACC_W:0]       rnd;
   logic signed [OUT_W-1:0]     outData_q, outData_d;
   logic                        v1_q, v2_q, outValid_q;
   logic                        adv;

   assign adv       = !outValid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign busy      = v1_q | v2_q | outValid_q;

   // Kernel writes are independent of the pipeline stall, so a window taken on the same edge sees the old value.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int c = 0; c < CH; c++)
            for (int r = 0; r < SIZE; r++)
               for (int k = 0; k < SIZE; k++)
                  kern_q[c][r][k] <= '0;
      end else if (k_we && CH_OK[k_ch] && IX_OK[k_row] && IX_OK[k_col]) begin
         kern_q[k_ch][k_row][k_col] <= k_data;
      end
   end

   always_comb begin
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < SIZE; r++)
            for (int k = 0; k < SIZE; k++)
               prod_d[c][r][k] = PW'($signed(in_win[((c*SIZE + r)*SIZE + k)*WIDTH_BIT +: WIDTH_BIT]))
                               * PW'(kern_q[c][r][k]);
   end

   always_comb begin
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < SIZE; r++) begin
            rowSum_d[c][r] = '0;
            for (int k = 0; k < SIZE; k++)
               rowSum_d[c][r] = rowSum_d[c][r] + ACC_W'(prod_q[c][r][k]);
         end
   end

   // One extra bit keeps the round-half-up addition from overflowing before the shift.
   always_comb begin
      total = '0;
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < SIZE; r++)
            total = total + rowSum_q[c][r];
      rnd = ((ACC_W+1)'(total) + RND_ADD) >>> OUT_SHIFT;
`ifdef CONV_SAT_EN
      if (rnd > (ACC_W+1)'((2 ** (OUT_W-1)) - 1))
         outData_d = {1'b0, {(OUT_W-1){1'b1}}};
      else if (rnd < -((ACC_W+1)'(2 ** (OUT_W-1))))
         outData_d = {1'b1, {(OUT_W-1){1'b0}}};
      else
         outData_d = rnd[OUT_W-1:0];
`else
      outData_d = rnd[OUT_W-1:0];
`endif
   end

   // All stages share a single advance enable; bubbles travel with the data.
   always_ff @(posedge clock) begin
      if (reset) begin
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
      end else if (adv) begin
         v1_q       <= in_valid;
         prod_q     <= prod_d;
         v2_q       <= v1_q;
         rowSum_q   <= rowSum_d;
         outValid_q <= v2_q;
         outData_q  <= outData_d;
      end
   end

endmodule

// File: tb/tb_conv_pipe_mc.sv
// Bench for conv_pipe_mc: directed scenarios plus random streaming against a
// whole-window arithmetic model. Two instances run in lockstep (OUT_SHIFT 0 and 2).
module tb_conv_pipe_mc;

   localparam int SIZE = 3;
   localparam int WB   = 8;
   localparam int CH   = 2;
   localparam int NW   = CH*SIZE*SIZE*WB;

   logic          clock = 1'b0;
   logic          reset, k_we, in_valid, out_ready;
   logic [0:0]    k_ch;
   logic [1:0]    k_row, k_col;
   logic [7:0]    k_data;
   logic [NW-1:0] in_win;
   logic          in_ready, out_valid, busy;
   logic          in_ready2, out_valid2, busy2;
   logic [7:0]    out_data, out_data2;

   int  kern [CH][SIZE][SIZE];
   int  win  [CH][SIZE][SIZE];
   bit  pv   [3];
   logic [7:0] pd0 [3];
   logic [7:0] pd2 [3];
   bit  outKnown;
   bit  lastAccepted;
   int  vectors = 0;
   int  miscompares = 0;

   always #5 clock = ~clock;

   conv_pipe_mc #(.SIZE(SIZE), .WIDTH_BIT(WB), .CH(CH), .OUT_SHIFT(0), .OUT_W(8)) dut (
      .clock(clock), .reset(reset), .k_we(k_we), .k_ch(k_ch), .k_row(k_row), .k_col(k_col),
      .k_data(k_data), .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

   conv_pipe_mc #(.SIZE(SIZE), .WIDTH_BIT(WB), .CH(CH), .OUT_SHIFT(2), .OUT_W(8)) dut2 (
      .clock(clock), .reset(reset), .k_we(k_we), .k_ch(k_ch), .k_row(k_row), .k_col(k_col),
      .k_data(k_data), .in_valid(in_valid), .in_ready(in_ready2), .in_win(in_win),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .busy(busy2));

   // Expected output for a full-precision window total under a given shift.
   function automatic logic [7:0] refResult(input int total, input int shift);
      int r;
      r = total;
      if (shift > 0) r = (total + (1 << (shift-1))) >>> shift;
`ifdef CONV_SAT_EN
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
`endif
      return r[7:0];
   endfunction

   function automatic int windowTotal();
      int t;
      t = 0;
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < SIZE; r++)
            for (int k = 0; k < SIZE; k++)
               t += win[c][r][k] * kern[c][r][k];
      return t;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fillWindow(input int v0, input int v1);
      for (int r = 0; r < SIZE; r++)
         for (int k = 0; k < SIZE; k++) begin
            win[0][r][k] = v0;
            win[1][r][k] = v1;
         end
   endtask

   task automatic checkOutput();
      bit adv;
      adv = !pv[2] || out_ready;
      check("in_ready", in_ready, adv);
      check("in_ready2", in_ready2, adv);
      check("busy", busy, pv[0] | pv[1] | pv[2]);
      check("busy2", busy2, pv[0] | pv[1] | pv[2]);
      check("out_valid", out_valid, pv[2]);
      check("out_valid2", out_valid2, pv[2]);
      if (pv[2] || outKnown) begin
         check("out_data", out_data, pd0[2]);
         check("out_data_shift2", out_data2, pd2[2]);
      end
   endtask

   // Model of one clock edge: accepted windows enter a 3-deep delay line that only moves on advance.
   task automatic modelEdge();
      int t;
      if (reset) begin
         for (int i = 0; i < 3; i++) pv[i] = 1'b0;
         pd0[2] = 8'd0;
         pd2[2] = 8'd0;
         outKnown = 1'b1;
         for (int c = 0; c < CH; c++)
            for (int r = 0; r < SIZE; r++)
               for (int k = 0; k < SIZE; k++)
                  kern[c][r][k] = 0;
      end else begin
         if (!pv[2] || out_ready) begin
            outKnown = 1'b0;
            pv[2] = pv[1]; pd0[2] = pd0[1]; pd2[2] = pd2[1];
            pv[1] = pv[0]; pd0[1] = pd0[0]; pd2[1] = pd2[0];
            pv[0] = in_valid;
            if (in_valid) begin
               t = windowTotal();
               pd0[0] = refResult(t, 0);
               pd2[0] = refResult(t, 2);
            end
         end
         if (k_we && k_row < SIZE && k_col < SIZE)
            kern[k_ch][k_row][k_col] = int'($signed(k_data));
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit vld, input bit ordy, input bit we = 1'b0,
                                input int wch = 0, input int wrow = 0, input int wcol = 0,
                                input int wdata = 0);
      reset     = rst;
      in_valid  = vld;
      out_ready = ordy;
      k_we      = we;
      k_ch      = wch[0:0];
      k_row     = wrow[1:0];
      k_col     = wcol[1:0];
      k_data    = wdata[7:0];
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < SIZE; r++)
            for (int k = 0; k < SIZE; k++)
               in_win[((c*SIZE + r)*SIZE + k)*WB +: WB] = 8'(win[c][r][k]);
      #1;
      checkOutput();
      lastAccepted = !rst && vld && (!pv[2] || ordy);
      modelEdge();
      @(posedge clock);
      #1;
   endtask

   task automatic loadKernel(input int val);
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < SIZE; r++)
            for (int k = 0; k < SIZE; k++)
               applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, c, r, k, val);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int sent, stallLeft, delivered;
      bit stallDone, pending;

      reset = 1'b1; k_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      k_ch = '0; k_row = '0; k_col = '0; k_data = '0; in_win = '0;
      fillWindow(0, 0);
      repeat (2) @(posedge clock);
      #1;
      modelEdge();
      $display("[TB] reset and T1 all-ones");
      applyStimulus(1'b1, 1'b0, 1'b1);
      loadKernel(1);
      fillWindow(1, 1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      idle(4);

      $display("[TB] T3 negative rounding");
      loadKernel(-1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      idle(4);

      $display("[TB] T2 extreme magnitude");
      loadKernel(-128);
      fillWindow(-128, -128);
      applyStimulus(1'b0, 1'b1, 1'b1);
      idle(4);

      $display("[TB] T4 stream with output stall");
      loadKernel(1);
      sent = 0; stallLeft = 0; stallDone = 1'b0; delivered = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         case (sent)
            0:       fillWindow(1, 1);
            1:       fillWindow(1, 0);
            2:       fillWindow(0, 0);
            default: fillWindow(-1, 0);
         endcase
         if (pv[2] && !stallDone) begin
            stallLeft = 5;
            stallDone = 1'b1;
         end
         if (out_valid && stallLeft == 0) delivered++;
         applyStimulus(1'b0, sent < 4, stallLeft == 0);
         if (lastAccepted) sent++;
         if (stallLeft > 0) stallLeft--;
      end
      check("t4_delivered", delivered, 4);

      $display("[TB] T5 kernel write alongside accept");
      loadKernel(1);
      fillWindow(1, 1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0, 5);
      applyStimulus(1'b0, 1'b1, 1'b1);
      idle(4);

      $display("[TB] T6 reset with data in flight");
      loadKernel(1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 7);
      applyStimulus(1'b0, 1'b1, 1'b1);
      idle(4);

      $display("[TB] random stream");
      pending = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!pending && $urandom_range(0, 3) != 0) begin
            for (int c = 0; c < CH; c++)
               for (int r = 0; r < SIZE; r++)
                  for (int k = 0; k < SIZE; k++)
                     win[c][r][k] = int'($urandom_range(0, 255)) - 128;
            pending = 1'b1;
         end
         applyStimulus(1'b0, pending, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
         if (lastAccepted) pending = 1'b0;
      end
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
